doro_sweep_ctrl: RTL and testbench

Sequencer that exhaustively drives the 4-input doro logic cell (F = A&~B | ~C&D) through all 16 input vectors and captures F into a 16-bit truth-table register.
- Sits between a host/test controller (start/done handshake) and a doro instance: drives its A..D, samples its F.
- Supports a programmable settle time per vector and a pause input.

---
 rtl/doro_sweep_pkg.sv | 12 +
 rtl/doro_sweep_cnt.sv | 43 ++++
 rtl/doro_sweep_ctrl.sv | 113 +++++++++++
 tb/tb_doro_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/doro_sweep_pkg.sv
// Shared definitions for the doro truth-table sweeper: state encoding,
// default vector width and the golden doro truth table.
package doro_sweep_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int VEC_W_DEF = 4;

  // F = A&~B | ~C&D, bit i is F for abcd == i
  localparam logic [15:0] GOLDEN_TT = 16'h2F22;

endpackage

// File: rtl/doro_sweep_cnt.sv
// Settle down-counter and vector counter for the doro sweep; sample fires on
// the settle terminal count, and the vector stops at its last value.
module doro_sweep_cnt
  import doro_sweep_pkg::*;
#(
  parameter int VEC_W  = VEC_W_DEF,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [VEC_W-1:0] vec,
  output logic             sample,
  output logic             last
);

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  logic [7:0] cnt;

  assign sample = enable && (cnt == 8'd0);
  assign last   = (vec == {VEC_W{1'b1}});

  // terminal compare precedes the increment, so vec never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec <= '0;
      cnt <= '0;
    end else if (clear) begin
      vec <= '0;
      cnt <= RELOAD;
    end else if (enable) begin
      if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else if (!last) begin
        vec <= vec + VEC_W'(1);
        cnt <= RELOAD;
      end
    end
  end

endmodule

// File: rtl/doro_sweep_ctrl.sv
// Sweeps a doro cell through every input vector and captures F into a truth
// table. Define DORO_SWEEP_CHECK_EN to compare each sample against GOLDEN_TT.
//
// state | meaning
// IDLE  | waiting for start; table_out/table_valid hold the last sweep
// WAIT  | driving abcd=vec, settling then sampling f_in
// DONE  | one-cycle completion pulse
module doro_sweep_ctrl
  import doro_sweep_pkg::*;
#(
  parameter int VEC_W  = VEC_W_DEF,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  output logic [VEC_W-1:0]      abcd,
  input  logic                  f_in,
  output logic                  busy,
  output logic                  done,
  output logic [2**VEC_W-1:0]   table_out,
  output logic                  table_valid,
  output logic                  err,
  output logic [VEC_W-1:0]      err_vec
);

  localparam int TBL_W = 2**VEC_W;

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("doro_sweep_ctrl: SETTLE must be within 1..255");
  end

  state_t           state, state_nxt;
  logic             accept;
  logic             cnt_en;
  logic             sample;
  logic             last;
  logic [VEC_W-1:0] vec;

  assign cnt_en = (state == WAIT) && !hold;

  doro_sweep_cnt #(
    .VEC_W  (VEC_W),
    .SETTLE (SETTLE)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (cnt_en),
    .vec    (vec),
    .sample (sample),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:    if (sample && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign abcd = vec;
  assign busy = (state == WAIT);
  assign done = (state == DONE);

  // table_out is overwritten bit by bit rather than cleared on start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      table_out   <= '0;
      table_valid <= 1'b0;
    end else begin
      if (accept)              table_valid <= 1'b0;
      else if (sample && last) table_valid <= 1'b1;
      if (sample) table_out[vec] <= f_in;
    end
  end

`ifdef DORO_SWEEP_CHECK_EN
  localparam logic [TBL_W-1:0] GOLDEN = TBL_W'(GOLDEN_TT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_vec <= '0;
    end else if (accept) begin
      err     <= 1'b0;
      err_vec <= '0;
    end else if (sample && !err && (f_in != GOLDEN[vec])) begin
      err     <= 1'b1;
      err_vec <= vec;
    end
  end
`else
  assign err     = 1'b0;
  assign err_vec = '0;
`endif

endmodule

// File: tb/tb_doro_sweep_ctrl.sv
// Scoreboard bench for doro_sweep_ctrl: two instances (SETTLE=1 and 3) each
// driven by a behavioural doro; expected sweeps are queued, monitors check done.
module tb_doro_sweep_ctrl;

  typedef struct {
    logic [15:0] tbl;
    logic        e;
    logic [3:0]  ev;
    int          dcyc;
  } exp_t;

`ifdef DORO_SWEEP_CHECK_EN
  localparam logic       INJ_ERR = 1'b1;
  localparam logic [3:0] INJ_EV  = 4'd3;
`else
  localparam logic       INJ_ERR = 1'b0;
  localparam logic [3:0] INJ_EV  = 4'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic        rst_n;
  logic        start_a, hold_a, inj_a, f_a;
  logic [3:0]  abcd_a, ev_a;
  logic        busy_a, done_a, tv_a, err_a;
  logic [15:0] tbl_a;
  logic        start_b, hold_b, f_b;
  logic [3:0]  abcd_b, ev_b;
  logic        busy_b, done_b, tv_b, err_b;
  logic [15:0] tbl_b;

  function automatic logic doro(input logic [3:0] v);
    return (v[3] & ~v[2]) | (~v[1] & v[0]);
  endfunction

  assign f_a = doro(abcd_a) | (inj_a && abcd_a == 4'd3);
  assign f_b = doro(abcd_b);

  doro_sweep_ctrl #(.VEC_W(4), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a), .abcd(abcd_a),
    .f_in(f_a), .busy(busy_a), .done(done_a), .table_out(tbl_a),
    .table_valid(tv_a), .err(err_a), .err_vec(ev_a)
  );

  doro_sweep_ctrl #(.VEC_W(4), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_b), .abcd(abcd_b),
    .f_in(f_b), .busy(busy_b), .done(done_b), .table_out(tbl_b),
    .table_valid(tv_b), .err(err_b), .err_vec(ev_b)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        cmp("a_done_cycle", cyc, e.dcyc);
        cmp("a_table", tbl_a, e.tbl);
        cmp("a_table_valid", tv_a, 1);
        cmp("a_busy_in_done", busy_a, 0);
        cmp("a_err", err_a, e.e);
        cmp("a_err_vec", ev_a, e.ev);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        cmp("b_done_cycle", cyc, e.dcyc);
        cmp("b_table", tbl_b, e.tbl);
        cmp("b_table_valid", tv_b, 1);
        cmp("b_err", err_b, e.e);
      end
    end
  end

  task automatic wait_drained(input bit sel_b, input int budget);
    int n = 0;
    while ((sel_b ? q_b.size() : q_a.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=done", sel_b ? "b" : "a");
      q_a.delete();
      q_b.delete();
    end
    @(negedge clk);
  endtask

  int acc;

  initial begin
    rst_n = 1'b0; start_a = 0; hold_a = 0; inj_a = 0; start_b = 0; hold_b = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("rst_abcd", abcd_a, 0);
    cmp("rst_busy", busy_a, 0);
    cmp("rst_done", done_a, 0);
    cmp("rst_table", tbl_a, 0);
    cmp("rst_valid", tv_a, 0);
    cmp("rst_err", {err_a, ev_a}, 0);

    // 1: SETTLE=1 sweep, one vector per cycle
    acc = cyc + 1;
    start_a = 1;
    q_a.push_back('{tbl: 16'h2F22, e: 1'b0, ev: 4'd0, dcyc: acc + 16});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start_a = 0;
      cmp("t1_abcd", abcd_a, k);
      cmp("t1_busy", busy_a, 1);
    end
    wait_drained(1'b0, 40);
    cmp("t1_valid_idle", tv_a, 1);
    cmp("t1_abcd_kept", abcd_a, 4'hF);
    cmp("t1_done_low", done_a, 0);

    // 2: SETTLE=3 sweep, each vector held three cycles
    acc = cyc + 1;
    start_b = 1;
    q_b.push_back('{tbl: 16'h2F22, e: 1'b0, ev: 4'd0, dcyc: acc + 48});
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      start_b = 0;
      cmp("t2_abcd", abcd_b, k / 3);
    end
    wait_drained(1'b1, 40);

    // start and hold together in IDLE: accepted, then frozen two cycles
    acc = cyc + 1;
    start_b = 1;
    hold_b = 1;
    q_b.push_back('{tbl: 16'h2F22, e: 1'b0, ev: 4'd0, dcyc: acc + 50});
    @(negedge clk);
    start_b = 0;
    cmp("t2h_busy", busy_b, 1);
    @(negedge clk);
    @(negedge clk);
    hold_b = 0;
    wait_drained(1'b1, 80);

    // 3: hold for five cycles at abcd=7
    acc = cyc + 1;
    start_a = 1;
    q_a.push_back('{tbl: 16'h2F22, e: 1'b0, ev: 4'd0, dcyc: acc + 21});
    @(negedge clk);
    start_a = 0;
    repeat (7) @(negedge clk);
    cmp("t3_abcd_at_hold", abcd_a, 7);
    hold_a = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmp("t3_abcd_held", abcd_a, 7);
    end
    hold_a = 0;
    @(negedge clk);
    cmp("t3_abcd_resume", abcd_a, 8);
    wait_drained(1'b0, 40);

    // 4: start re-pulsed mid-sweep is ignored
    acc = cyc + 1;
    start_a = 1;
    q_a.push_back('{tbl: 16'h2F22, e: 1'b0, ev: 4'd0, dcyc: acc + 16});
    @(negedge clk);
    start_a = 0;
    repeat (4) @(negedge clk);
    cmp("t4_abcd4", abcd_a, 4);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    cmp("t4_abcd5", abcd_a, 5);
    wait_drained(1'b0, 40);
    repeat (3) @(negedge clk);

    // 5: reset at abcd=9 aborts with no done
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (9) @(negedge clk);
    cmp("t5_abcd9", abcd_a, 9);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    cmp("t5_abcd", abcd_a, 0);
    cmp("t5_busy", busy_a, 0);
    cmp("t5_table", tbl_a, 0);
    cmp("t5_valid", tv_a, 0);
    cmp("t5_err", {err_a, ev_a}, 0);
    repeat (20) @(negedge clk);
    acc = cyc + 1;
    start_a = 1;
    q_a.push_back('{tbl: 16'h2F22, e: 1'b0, ev: 4'd0, dcyc: acc + 16});
    @(negedge clk);
    start_a = 0;
    wait_drained(1'b0, 40);

    // 6: F forced high at vector 3
    inj_a = 1;
    acc = cyc + 1;
    start_a = 1;
    q_a.push_back('{tbl: 16'h2F2A, e: INJ_ERR, ev: INJ_EV, dcyc: acc + 16});
    @(negedge clk);
    start_a = 0;
    wait_drained(1'b0, 40);
    cmp("t6_err_sticky", {err_a, ev_a}, {INJ_ERR, INJ_EV});
    inj_a = 0;
    acc = cyc + 1;
    start_a = 1;
    q_a.push_back('{tbl: 16'h2F22, e: 1'b0, ev: 4'd0, dcyc: acc + 16});
    @(negedge clk);
    start_a = 0;
    cmp("t6_err_cleared", {err_a, ev_a}, 0);
    wait_drained(1'b0, 40);

    cmp("final_queue_a", q_a.size(), 0);
    cmp("final_queue_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
